// File: rtl/imem_loader_pkg.sv
// Shared state encoding and constants for the instruction-memory loader.
// Macro IMEM_LOADER_CHECKSUM_EN adds the CHECK state to the encoding.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd4
    } state_t;
`endif

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler: the first byte of a word lands in bits 7:0.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word_next,
    output logic [BCNT_W-1:0] byte_cnt
);

    logic [WORD_W-1:0] word_r;

    // Shifting right keeps the oldest byte at the bottom once the word is full.
    assign word_next = {byte_in, word_r[WORD_W-1:8]};

    // Shift register and byte counter; the counter wraps naturally after the last byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_r   <= {WORD_W{1'b0}};
            byte_cnt <= {BCNT_W{1'b0}};
        end else if (clear) begin
            word_r   <= {WORD_W{1'b0}};
            byte_cnt <= {BCNT_W{1'b0}};
        end else if (accept) begin
            word_r   <= word_next;
            byte_cnt <= byte_cnt + BCNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory while holding the core in reset.
// Macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the err flag.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len_words,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int LEN_W = ADDR_W + 1;

    state_t            state_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  word_cnt_r;
    logic              loaded_r;
    logic              recv_accept_s;
    logic              last_byte_s;
    logic              pack_clear_s;
    logic [BCNT_W-1:0] byte_cnt_s;
    logic [WORD_W-1:0] word_next_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_r;
    logic       err_r;
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign recv_accept_s = (state_r == RECV) && s_valid && s_ready;
    assign last_byte_s   = recv_accept_s && (byte_cnt_s == BCNT_W'(BYTES_PER_WORD - 1));
    assign pack_clear_s  = (state_r == IDLE) && start;

    imem_word_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (pack_clear_s),
        .accept    (recv_accept_s),
        .byte_in   (s_data),
        .word_next (word_next_s),
        .byte_cnt  (byte_cnt_s)
    );

    // Load sequencer; every output is registered alongside the state it belongs to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            len_r      <= {LEN_W{1'b0}};
            word_cnt_r <= {LEN_W{1'b0}};
            loaded_r   <= 1'b0;
            s_ready    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= {ADDR_W{1'b0}};
            mem_wdata  <= 32'h0000_0000;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r     <= 8'h00;
            err_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        len_r      <= len_words;
                        word_cnt_r <= {LEN_W{1'b0}};
                        busy       <= 1'b1;
                        core_reset <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r     <= 8'h00;
                        err_r      <= 1'b0;
`endif
                        if (len_words == {LEN_W{1'b0}}) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= RECV;
                            s_ready <= 1'b1;
                        end
                    end
                end
                RECV: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (recv_accept_s) begin
                        csum_r <= csum_update(csum_r, s_data);
                    end
`endif
                    // The completed word is captured from the packer's next value on its last byte.
                    if (last_byte_s) begin
                        state_r   <= WRITE;
                        s_ready   <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_addr  <= word_cnt_r[ADDR_W-1:0];
                        mem_wdata <= word_next_s;
                    end
                end
                WRITE: begin
                    mem_we     <= 1'b0;
                    word_cnt_r <= word_cnt_r + LEN_W'(1);
                    if (word_cnt_r == len_r - LEN_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_r <= CHECK;
                        s_ready <= 1'b1;
`else
                        state_r <= DONE;
                        done    <= 1'b1;
`endif
                    end else begin
                        state_r <= RECV;
                        s_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (s_valid && s_ready) begin
                        err_r   <= (s_data != csum_r);
                        s_ready <= 1'b0;
                        state_r <= DONE;
                        done    <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    loaded_r   <= 1'b1;
                    core_reset <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    s_ready    <= 1'b0;
                    mem_we     <= 1'b0;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    core_reset <= ~loaded_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed vector table, hand-written
// reset/start corner cases and randomized loads checked against a word model.
module tb_imem_loader;

    localparam int AW = 4;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CKS_EN = 1'b1;
`else
    localparam bit CKS_EN = 1'b0;
`endif

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];
    typedef struct {
        string       name;
        int          len;
        int          gap;
        logic [63:0] bytes;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [7:0]  delta;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   len_words = '0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_reset;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int ready_cnt = 0;
    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];

    imem_loader #(.ADDR_W(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .len_words  (len_words),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clock = ~clock;

    // Observe writes, done pulses and ready cycles on the inactive edge.
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (s_ready) ready_cnt = ready_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_obs();
        wa_q.delete();
        wd_q.delete();
        done_cnt  = 0;
        ready_cnt = 0;
    endtask

    // Reference: each group of four stream bytes forms one word, first byte least significant.
    function automatic wq_t model_words(input bq_t b);
        wq_t w;
        logic [31:0] acc;
        for (int i = 0; i < b.size() / 4; i++) begin
            acc = 32'h0;
            for (int k = 0; k < 4; k++) acc = acc + (32'(b[4*i+k]) << (8*k));
            w.push_back(acc);
        end
        return w;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t b;
        for (int i = 0; i < n; i++) b.push_back(8'($urandom_range(0, 255)));
        return b;
    endfunction

    // gap: 0 = always valid, 1 = valid every other cycle, 2 = random valid.
    // poke >= 0 raises start (with a different length) while that byte index is pending.
    task automatic do_load(input string name, input int len, input int gap, input bq_t bytes,
                           input wq_t exp_w, input logic [7:0] cks_delta, input int poke);
        bq_t        stream;
        logic [7:0] cks;
        logic       exp_err;
        logic       fire;
        logic       tog;
        int         idx, t, start_c, budget;
        cks = 8'h00;
        foreach (bytes[k]) cks = cks ^ bytes[k];
        stream = bytes;
        if (CKS_EN && len > 0) stream.push_back(cks ^ cks_delta);
        exp_err = CKS_EN && (len > 0) && (cks_delta != 8'h00);
        budget  = 40 * (len + 1) * 4 + 50;
        clear_obs();
        tick();
        start     = 1'b1;
        len_words = (AW+1)'(len);
        start_c   = cyc;
        idx = 0;
        t   = 0;
        tog = 1'b1;
        while (idx < stream.size() && t < budget) begin
            tick();
            start   = (idx == poke);
            len_words = (idx == poke) ? (AW+1)'(len + 2) : (AW+1)'(len);
            s_valid = (gap == 0) ? 1'b1 : (gap == 1) ? tog : 1'($urandom_range(0, 1));
            tog     = ~tog;
            s_data  = stream[idx];
            fire    = s_valid && s_ready;
            if (fire) idx++;
            t++;
        end
        tick();
        s_valid = 1'b0;
        start   = 1'b0;
        if (idx < stream.size()) check({name, " stream_timeout"}, idx, stream.size());
        t = 0;
        while (!(busy == 1'b0 && done_cnt > 0) && t < budget) begin
            tick();
            t++;
        end
        check({name, " finished"}, {busy, 1'(done_cnt > 0)}, 2'b01);
        check({name, " writes"}, wa_q.size(), exp_w.size());
        for (int i = 0; i < wa_q.size() && i < exp_w.size(); i++) begin
            check({name, " addr"}, 32'(wa_q[i]), i);
            check({name, " data"}, wd_q[i], exp_w[i]);
        end
        check({name, " done_pulses"}, done_cnt, 1);
        check({name, " core_reset"}, core_reset, 1'b0);
        check({name, " err"}, err, exp_err);
        if (len == 0) begin
            check({name, " done_latency"}, done_cyc - start_c, 1);
            check({name, " ready_cycles"}, ready_cnt, 0);
        end
        if (gap == 0 && len > 0 && poke < 0)
            check({name, " throughput"}, 1'(done_cyc - start_c <= 5 * len + 1 + int'(CKS_EN)), 1'b1);
    endtask

    initial begin
        vec_t vecs[6];
        bq_t  b;
        wq_t  w;
        int   len, gap, got;

        vecs[0] = '{"two_words",    2, 0, 64'h0010_0093_0000_0013, 32'h0000_0013, 32'h0010_0093, 8'h00};
        vecs[1] = '{"toggle_valid", 1, 1, 64'h0000_0000_DEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 8'h00};
        vecs[2] = '{"random_gaps",  2, 2, 64'h8877_6655_4433_2211, 32'h4433_2211, 32'h8877_6655, 8'h00};
        vecs[3] = '{"zero_len",     0, 0, 64'h0,                   32'h0,         32'h0,         8'h00};
        vecs[4] = '{"cks_good",     1, 0, 64'h0000_0000_0000_0013, 32'h0000_0013, 32'h0000_0000, 8'h00};
        vecs[5] = '{"cks_bad",      1, 0, 64'h0000_0000_0000_0013, 32'h0000_0013, 32'h0000_0000, 8'h01};

        repeat (3) tick();
        check("rst s_ready", s_ready, 1'b0);
        check("rst mem_we", mem_we, 1'b0);
        check("rst mem_addr", 32'(mem_addr), 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst busy_done_err", {busy, done, err}, 3'b000);
        check("rst core_reset", core_reset, 1'b1);
        reset = 1'b0;
        repeat (2) tick();
        check("idle core_reset", core_reset, 1'b1);

        foreach (vecs[i]) begin
            b.delete();
            w.delete();
            for (int k = 0; k < 4 * vecs[i].len; k++) b.push_back(vecs[i].bytes[8*k +: 8]);
            if (vecs[i].len >= 1) w.push_back(vecs[i].exp0);
            if (vecs[i].len >= 2) w.push_back(vecs[i].exp1);
            do_load(vecs[i].name, vecs[i].len, vecs[i].gap, b, w, vecs[i].delta, -1);
        end
        repeat (3) tick();
        check("cks_bad err_held", err, CKS_EN);

        // Reset after two bytes of a word: abandon the load, nothing written.
        clear_obs();
        tick();
        start = 1'b1;
        len_words = (AW+1)'(1);
        tick();
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        got = 0;
        for (int t = 0; t < 20 && got < 2; t++) begin
            if (s_ready) got++;
            tick();
        end
        s_valid = 1'b0;
        reset   = 1'b1;
        #1;
        check("midrst bytes_sent", got, 2);
        check("midrst state", {busy, s_ready, mem_we, done}, 4'b0000);
        check("midrst core_reset", core_reset, 1'b1);
        repeat (2) tick();
        reset = 1'b0;
        repeat (8) tick();
        check("midrst writes", wa_q.size(), 0);
        check("midrst core_reset_held", core_reset, 1'b1);
        b = rand_bytes(4);
        do_load("after_reset", 1, 0, b, model_words(b), 8'h00, -1);

        b = rand_bytes(8);
        do_load("start_in_recv", 2, 0, b, model_words(b), 8'h00, 1);

        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 6);
            gap = $urandom_range(0, 2);
            b = rand_bytes(4 * len);
            do_load("random", len, gap, b, model_words(b),
                    ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00, -1);
        end

        b = rand_bytes(4 * (1 << AW));
        do_load("full_depth", 1 << AW, 0, b, model_words(b), 8'h00, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of instruction memory; depth is 2**ADDR_W words.
REQ-002 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  begin a load; sampled only in IDLE.
REQ-005 SHALL have port len_words  input  ADDR_W+1  number of words to load; latched when start is accepted.
REQ-006 SHALL have port s_valid  input  1  byte-stream valid.
REQ-007 SHALL have port s_data  input  8  byte-stream data.
REQ-008 SHALL have port s_ready  output  1  byte-stream ready; a byte is accepted on cycles where s_valid and s_ready are both 1.
REQ-009 SHALL have port mem_we  output  1  instruction-memory write enable.
REQ-010 SHALL have port mem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 SHALL have port mem_wdata  output  32  instruction-memory write data.
REQ-012 SHALL have port core_reset  output  1  holds the pipeline core in reset.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse marking load completion.
REQ-015 SHALL have port err  output  1  sticky checksum-mismatch flag.

Function
REQ-016 SHALL implement the states IDLE, RECV, WRITE, CHECK and DONE.
REQ-017 In IDLE, start=1 SHALL latch len_words, clear word_cnt, byte_cnt, the running XOR and err, then go to RECV; if len_words=0 it SHALL go to DONE instead.
REQ-018 In RECV, s_ready SHALL be 1, and each accepted byte SHALL be placed little-endian into the word (first byte into bits 7:0, fourth into bits 31:24) and XORed into the running checksum.
REQ-019 The 4th accepted byte SHALL move the FSM to WRITE on the next cycle, with byte_cnt wrapping to 0.
REQ-020 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_addr=word_cnt, mem_wdata equal to the assembled word, and s_ready=0.
REQ-021 On leaving WRITE, word_cnt SHALL increment; the FSM SHALL go to CHECK (if configured) or DONE when word_cnt equals len_words-1, otherwise back to RECV.
REQ-022 Minimum throughput SHALL be one word per 5 cycles; gaps in s_valid SHALL stall the FSM without losing or duplicating bytes.
REQ-023 In DONE, done SHALL be 1 for one cycle, after which the FSM returns to IDLE.
REQ-024 core_reset SHALL be 1 whenever busy=1 or no load has completed since reset, and SHALL be 0 in IDLE after a completed load.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 len_words=2**ADDR_W SHALL write every address 0..2**ADDR_W-1 with no wrap.
REQ-027 Outside WRITE, mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.

Reset
REQ-028 reset=1 SHALL asynchronously force state=IDLE, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, core_reset=1, and clear all counters and the loaded flag.
REQ-029 reset asserted mid-load SHALL abandon the load, and SHALL not write any partially assembled word.

Configuration
REQ-030 With macro IMEM_LOADER_CHECKSUM_EN defined, the last WRITE SHALL go to CHECK, which accepts one byte with s_ready=1; if that byte differs from the running XOR of all data bytes, err SHALL be set; the FSM then goes to DONE.
REQ-031 Without IMEM_LOADER_CHECKSUM_EN, the CHECK state SHALL be absent, no trailing byte SHALL be consumed, and err SHALL be constant 0.

Structure
REQ-032 Package imem_loader_pkg SHALL hold the state enum and the constant BYTES_PER_WORD=4.
REQ-033 Byte-to-word assembly (shift register and byte_cnt) SHALL be a sub-module named imem_word_packer.

Verification
REQ-034 Bench SHALL cover: len_words=2, bytes 13 00 00 00 93 00 10 00 -> writes addr0=0x00000013, addr1=0x00100093, done pulses once, core_reset falls.
REQ-035 Bench SHALL cover: len_words=1 with s_valid toggling every other cycle -> exactly one write of the correct word, no byte loss.
REQ-036 Bench SHALL cover: len_words=0 -> done one cycle after start, no mem_we, s_ready stays 0.
REQ-037 Bench SHALL cover: reset asserted after 2 bytes -> immediate IDLE, core_reset=1, no write; a following full load succeeds.
REQ-038 Bench SHALL cover, with CHECKSUM_EN: word 0x00000013 and checksum byte 0x13 -> err=0; checksum byte 0x12 -> err=1, still held after done.
REQ-039 Bench SHALL cover: start pulsed during RECV -> ignored, len_words unchanged, load completes normally.
